// File: rtl/cache_pkg.sv
// Shared cache-subsystem types and constants for the miss path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cache_pkg;

    // Line-fill responder FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } fill_state_e;

    localparam int WORD_BYTES         = 4;
    localparam int DEF_WORDS_PER_LINE = 4;
    localparam int LINE_OFF_BITS      = $clog2(DEF_WORDS_PER_LINE) + $clog2(WORD_BYTES);

    // Shared width of the fill counter and the cache's hit counter
    localparam int DEFAULT_CNT_W = 21;

    // Byte-offset bits within a line for a given line size in words
    function automatic int line_off_bits(input int words_per_line);
        return $clog2(words_per_line) + $clog2(WORD_BYTES);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; sticks at all-ones instead of wrapping.
// Latency: count reflects an inc one cycle after it is sampled.
// Backpressure: none; inc is an event strobe, clr has priority over inc.
module sat_counter
    import cache_pkg::*;
#(
    parameter int WIDTH = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    // Count events up to the all-ones ceiling, then hold
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/line_fill_responder.sv
// Memory-side responder for cache line fills with synthetic address-derived data.
// Latency: first beat valid LATENCY+1 cycles after the accept edge, then one beat per transfer.
// Backpressure: resp_* held stable while resp_ready=0; req_ready low from accept until burst done.
module line_fill_responder
    import cache_pkg::*;
#(
    parameter int          ADDR_W         = 32,
    parameter int          WORDS_PER_LINE = 4,
    parameter int          LATENCY        = 3,
    parameter logic [31:0] PATTERN        = 32'hA5A5_0000,
    parameter int          CNT_W          = DEFAULT_CNT_W,
    parameter int          IDX_W          = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_data,
    output logic [IDX_W-1:0]  resp_idx,
    output logic              resp_last,
    output logic [CNT_W-1:0]  fills
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_WAIT  = WAIT;
    localparam logic [1:0] ST_BURST = BURST;

    localparam int              LOB      = line_off_bits(WORDS_PER_LINE);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << LOB) - 64'd1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] base;
    logic [3:0]        cnt;
    logic [IDX_W-1:0]  idx;
    logic              last_beat;
    logic              fill_done;
    logic [ADDR_W-1:0] beat_addr;

    assign last_beat = (idx == LAST_IDX);
    assign fill_done = (state == ST_BURST) && resp_ready && last_beat;

    // Request accept, latency countdown and beat sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            base  <= '0;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        base  <= req_addr & ~OFF_MASK;
                        cnt   <= 4'(LATENCY);
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        idx   <= '0;
                        state <= ST_BURST;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_BURST: begin
                    if (resp_ready) begin
                        if (last_beat) begin
                            // idx returns to 0 so resp_idx idles at zero
                            idx   <= '0;
                            state <= ST_IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Base is line-aligned, so adding the word offset never crosses the line
    assign beat_addr = base + (ADDR_W'(idx) << $clog2(WORD_BYTES));

    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_BURST);
    assign resp_data  = resp_valid ? (32'(beat_addr) ^ PATTERN) : 32'd0;
    assign resp_idx   = idx;
    assign resp_last  = resp_valid && last_beat;

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_fills (
        .clk   (clk),
        .rst   (rst),
        .inc   (fill_done),
        .clr   (1'b0),
        .count (fills)
    );

endmodule

// File: tb/tb_line_fill_responder.sv
// Directed bench for line_fill_responder: reset, fill timing, backpressure, turnaround, abort, saturation.
// Latency: edges are counted by cyc; outputs are sampled on the falling edge.
// Backpressure: resp_ready is driven per scenario from the test tasks.
module tb_line_fill_responder;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        resp_ready;

    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [1:0]  resp_idx;
    logic        resp_last;
    logic [20:0] fills;

    logic        s_req_ready;
    logic        s_resp_valid;
    logic [31:0] s_resp_data;
    logic [1:0]  s_resp_idx;
    logic        s_resp_last;
    logic [2:0]  s_fills;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Observations from the most recent collect_burst
    logic [31:0] obs_dat  [4];
    logic [1:0]  obs_idx  [4];
    logic        obs_last [4];
    int          obs_beats;
    int          acc_edge;
    int          first_edge;
    int          done_edge;
    bit          held_ok;
    bit          timed_out;

    logic [31:0] exp_basic [4] = '{32'hA5A5_1230, 32'hA5A5_1234, 32'hA5A5_1238, 32'hA5A5_123C};

    line_fill_responder dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_idx   (resp_idx),
        .resp_last  (resp_last),
        .fills      (fills)
    );

    // Narrow-counter copy sharing all inputs, for the saturation case
    line_fill_responder #(.CNT_W(3)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (s_req_ready),
        .req_addr   (req_addr),
        .resp_valid (s_resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (s_resp_data),
        .resp_idx   (s_resp_idx),
        .resp_last  (s_resp_last),
        .fills      (s_fills)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter: at a falling edge, cyc is the index of the last rising edge
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        req_addr   = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Issue one request and record the returned burst; stalls beat stall_idx for stall_n cycles
    task automatic collect_burst(input logic [31:0] addr, input int stall_idx, input int stall_n);
        int guard;
        int beat;
        timed_out  = 1'b0;
        held_ok    = 1'b1;
        obs_beats  = 0;
        for (int i = 0; i < 4; i++) begin
            obs_dat[i] = 'x; obs_idx[i] = 'x; obs_last[i] = 1'bx;
        end
        req_addr   = addr;
        req_valid  = 1'b1;
        resp_ready = 1'b1;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        acc_edge = cyc + 1;
        @(negedge clk);
        req_valid = 1'b0;
        guard = 0;
        while (!resp_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!resp_valid) timed_out = 1'b1;
        first_edge = cyc;
        beat = 0;
        while (resp_valid && beat < 4) begin
            obs_dat[beat]  = resp_data;
            obs_idx[beat]  = resp_idx;
            obs_last[beat] = resp_last;
            if (beat == stall_idx) begin
                resp_ready = 1'b0;
                repeat (stall_n) begin
                    @(negedge clk);
                    if (!resp_valid || resp_data !== obs_dat[beat] ||
                        resp_idx !== obs_idx[beat] || resp_last !== obs_last[beat])
                        held_ok = 1'b0;
                end
                resp_ready = 1'b1;
            end
            @(negedge clk);
            beat++;
        end
        obs_beats = beat;
        done_edge = cyc;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        n_checks++; if (fills !== 21'd0) begin n_fail++; $display("FAIL reset_fills: got %0d expected 0", fills); end
        n_checks++; if (resp_data !== 32'd0) begin n_fail++; $display("FAIL reset_resp_data: got %h expected 0", resp_data); end
        n_checks++; if (resp_idx !== 2'd0 || resp_last !== 1'b0) begin n_fail++; $display("FAIL reset_idx_last: got idx=%0d last=%b expected 0/0", resp_idx, resp_last); end
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL idle_hold: got ready=%b valid=%b expected 1/0", req_ready, resp_valid); end
    endtask

    task automatic test_basic_fill();
        do_reset();
        collect_burst(32'h0000_1234, -1, 0);
        n_checks++; if (timed_out) begin n_fail++; $display("FAIL basic_timeout: resp_valid never rose, expected within 50 cycles"); end
        // First beat occupies the cycle starting LATENCY+1 edges after the accept edge
        n_checks++; if (first_edge - acc_edge !== 4) begin n_fail++; $display("FAIL basic_latency: got %0d edges expected 4", first_edge - acc_edge); end
        n_checks++; if (obs_beats !== 4) begin n_fail++; $display("FAIL basic_beats: got %0d expected 4", obs_beats); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (obs_dat[i] !== exp_basic[i]) begin n_fail++; $display("FAIL basic_data[%0d]: got %h expected %h", i, obs_dat[i], exp_basic[i]); end
            n_checks++; if (obs_idx[i] !== 2'(i)) begin n_fail++; $display("FAIL basic_idx[%0d]: got %0d expected %0d", i, obs_idx[i], i); end
            n_checks++; if (obs_last[i] !== (i == 3)) begin n_fail++; $display("FAIL basic_last[%0d]: got %b expected %b", i, obs_last[i], (i == 3)); end
        end
        n_checks++; if (done_edge - acc_edge !== 8) begin n_fail++; $display("FAIL basic_duration: got %0d edges expected 8", done_edge - acc_edge); end
        n_checks++; if (fills !== 21'd1) begin n_fail++; $display("FAIL basic_fills: got %0d expected 1", fills); end
        n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle_after: got ready=%b valid=%b expected 1/0", req_ready, resp_valid); end
    endtask

    task automatic test_backpressure();
        do_reset();
        collect_burst(32'h0000_1234, 1, 3);
        n_checks++; if (held_ok !== 1'b1) begin n_fail++; $display("FAIL bp_hold: outputs moved during stall, expected stable at idx 1"); end
        n_checks++; if (obs_dat[1] !== 32'hA5A5_1234 || obs_idx[1] !== 2'd1) begin n_fail++; $display("FAIL bp_beat1: got %h idx %0d expected a5a51234 idx 1", obs_dat[1], obs_idx[1]); end
        n_checks++; if (obs_dat[3] !== 32'hA5A5_123C || obs_last[3] !== 1'b1) begin n_fail++; $display("FAIL bp_beat3: got %h last %b expected a5a5123c last 1", obs_dat[3], obs_last[3]); end
        n_checks++; if (done_edge - acc_edge !== 11) begin n_fail++; $display("FAIL bp_duration: got %0d edges expected 11", done_edge - acc_edge); end
        n_checks++; if (fills !== 21'd1) begin n_fail++; $display("FAIL bp_fills: got %0d expected 1", fills); end
    endtask

    task automatic test_back_to_back();
        int acc1;
        int acc2;
        int guard;
        logic [31:0] d1;
        logic [31:0] d2;
        bit got1;
        do_reset();
        got1 = 1'b0;
        d1 = 'x;
        d2 = 'x;
        acc2 = -100;
        resp_ready = 1'b1;
        req_addr   = 32'h40;
        req_valid  = 1'b1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_first_ready: got %b expected 1", req_ready); end
        acc1 = cyc + 1;
        @(negedge clk);
        req_addr = 32'h80;
        guard = 0;
        while (!req_ready && guard < 60) begin
            if (resp_valid && !got1) begin d1 = resp_data; got1 = 1'b1; end
            @(negedge clk);
            guard++;
        end
        if (req_ready) acc2 = cyc + 1;
        @(negedge clk);
        req_valid = 1'b0;
        guard = 0;
        while (!resp_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        d2 = resp_data;
        guard = 0;
        while (!(resp_valid && resp_last) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        n_checks++; if (acc2 - acc1 !== 9) begin n_fail++; $display("FAIL b2b_spacing: got %0d edges expected 9", acc2 - acc1); end
        n_checks++; if (d1 !== 32'hA5A5_0040) begin n_fail++; $display("FAIL b2b_first_data: got %h expected a5a50040", d1); end
        n_checks++; if (d2 !== 32'hA5A5_0080) begin n_fail++; $display("FAIL b2b_second_data: got %h expected a5a50080", d2); end
        n_checks++; if (fills !== 21'd2) begin n_fail++; $display("FAIL b2b_fills: got %0d expected 2", fills); end
    endtask

    task automatic test_reset_mid_burst();
        int guard;
        do_reset();
        resp_ready = 1'b1;
        req_addr   = 32'h0000_2000;
        req_valid  = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        guard = 0;
        while (!resp_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        n_checks++; if (resp_idx !== 2'd1 || resp_data !== 32'hA5A5_2004) begin n_fail++; $display("FAIL abort_pre_idx: got idx %0d data %h expected 1 a5a52004", resp_idx, resp_data); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL abort_state: got valid=%b ready=%b expected 0/1", resp_valid, req_ready); end
        n_checks++; if (fills !== 21'd0) begin n_fail++; $display("FAIL abort_fills: got %0d expected 0", fills); end
        n_checks++; if (resp_idx !== 2'd0 || resp_data !== 32'd0 || resp_last !== 1'b0) begin n_fail++; $display("FAIL abort_outputs: got idx=%0d data=%h last=%b expected 0/0/0", resp_idx, resp_data, resp_last); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (resp_valid !== 1'b0 || fills !== 21'd0) begin n_fail++; $display("FAIL abort_stays_idle: got valid=%b fills=%0d expected 0/0", resp_valid, fills); end
    endtask

    task automatic test_addr_wrap();
        do_reset();
        collect_burst(32'hFFFF_FFF7, -1, 0);
        n_checks++; if (obs_dat[0] !== 32'h5A5A_FFF0) begin n_fail++; $display("FAIL wrap_beat0: got %h expected 5a5afff0", obs_dat[0]); end
        n_checks++; if (obs_dat[3] !== 32'h5A5A_FFFC || obs_last[3] !== 1'b1) begin n_fail++; $display("FAIL wrap_beat3: got %h last %b expected 5a5afffc last 1", obs_dat[3], obs_last[3]); end
    endtask

    task automatic test_saturation();
        logic [31:0] a;
        logic [31:0] exp0;
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            a = 32'(i * 64 + 8);
            exp0 = (a & ~32'hF) ^ 32'hA5A5_0000;
            collect_burst(a, -1, 0);
            n_checks++; if (obs_dat[0] !== exp0) begin n_fail++; $display("FAIL sat_data[%0d]: got %h expected %h", i, obs_dat[0], exp0); end
            n_checks++; if (fills !== 21'(i)) begin n_fail++; $display("FAIL sat_wide_fills[%0d]: got %0d expected %0d", i, fills, i); end
            n_checks++; if (s_fills !== ((i < 7) ? 3'(i) : 3'd7)) begin n_fail++; $display("FAIL sat_narrow_fills[%0d]: got %0d expected %0d", i, s_fills, (i < 7) ? i : 7); end
        end
        n_checks++; if (s_req_ready !== 1'b1 || s_resp_valid !== 1'b0 || s_resp_last !== 1'b0 || s_resp_idx !== 2'd0 || s_resp_data !== 32'd0) begin
            n_fail++; $display("FAIL sat_idle_outputs: got ready=%b valid=%b last=%b idx=%0d data=%h expected 1/0/0/0/0", s_req_ready, s_resp_valid, s_resp_last, s_resp_idx, s_resp_data);
        end
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = 32'd0;
        resp_ready = 1'b0;
        test_reset();
        test_basic_fill();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_burst();
        test_addr_wrap();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
